// File: rtl/bpsk_demod_seq.sv
// BPSK symbol-stream sequencer: packs N serial 2-bit symbols, demodulates them and hands the word downstream.
// Optional build macro SYMERR_CNT_EN adds err_cnt, a per-word count of non-canonical symbols.

module BPSK_demod #(
  parameter int n = 12
) (
  input  logic [2*n-1:0] sym,
  output logic [n-1:0]   bits
);
  // 2'b01 is the only symbol that demaps to 0
  for (genvar gi = 0; gi < n; gi++) begin : g_demap
    assign bits[gi] = (sym[2*gi +: 2] != 2'b01);
  end
endmodule

module bpsk_demod_seq #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   sym_in,
  input  logic         sym_valid,
  output logic         sym_ready,
  input  logic         sym_sop,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         word_bad,
  output logic         drop_pulse,
`ifdef SYMERR_CNT_EN
  output logic [3:0]   err_cnt,
`endif
  output logic         busy
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [2*N-1:0]   buf_reg, buf_next;
  logic             bad_reg, bad_next;
  logic             drop_next;
  logic             load_word;
  logic             accept;
  logic             non_canon;
  logic [N-1:0]     demod_bits;
  logic [N-1:0]     word_out_reg;
  logic             word_valid_reg, word_bad_reg, drop_pulse_reg, busy_reg;

  assign sym_ready = (state_reg != HOLD);
  assign accept    = sym_valid && sym_ready;
  assign non_canon = (sym_in == 2'b00) || (sym_in == 2'b11);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    buf_next   = buf_reg;
    bad_next   = bad_reg;
    drop_next  = 1'b0;
    load_word  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          buf_next[1:0] = sym_in;
          cnt_next      = CW'(1);
          bad_next      = non_canon;
          if (N == 1) begin
            state_next = HOLD;
            load_word  = 1'b1;
          end else begin
            state_next = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (sym_sop) begin
            // sop mid-word: drop the fragment, this symbol restarts the word
            buf_next[1:0] = sym_in;
            cnt_next      = CW'(1);
            bad_next      = non_canon;
            drop_next     = 1'b1;
          end else begin
            for (int k = 0; k < N; k++) begin
              if (cnt_reg == CW'(k)) buf_next[2*k +: 2] = sym_in;
            end
            cnt_next = cnt_reg + 1'b1;
            bad_next = bad_reg | non_canon;
            if (cnt_reg == CW'(N - 1)) begin
              state_next = HOLD;
              load_word  = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // demod sees the next buffer so the final symbol lands in the same load
  BPSK_demod #(.n(N)) u_demod (
    .sym  (buf_next),
    .bits (demod_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      buf_reg        <= '0;
      bad_reg        <= 1'b0;
      word_out_reg   <= '0;
      word_valid_reg <= 1'b0;
      word_bad_reg   <= 1'b0;
      drop_pulse_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      buf_reg        <= buf_next;
      bad_reg        <= bad_next;
      drop_pulse_reg <= drop_next;
      word_valid_reg <= (state_next == HOLD);
      busy_reg       <= (state_next != IDLE);
      if (load_word) begin
        word_out_reg <= demod_bits;
        word_bad_reg <= bad_next;
      end
    end
  end

  assign word_out   = word_out_reg;
  assign word_valid = word_valid_reg;
  assign word_bad   = word_bad_reg;
  assign drop_pulse = drop_pulse_reg;
  assign busy       = busy_reg;

`ifdef SYMERR_CNT_EN
  logic [3:0] err_run_reg, err_run_next;
  logic [3:0] err_cnt_reg;

  always_comb begin
    err_run_next = err_run_reg;
    if (accept) begin
      if (state_reg == IDLE || (state_reg == COLLECT && sym_sop)) begin
        err_run_next = {3'b000, non_canon};
      end else if (state_reg == COLLECT && non_canon && err_run_reg != 4'hF) begin
        err_run_next = err_run_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_run_reg <= 4'd0;
      err_cnt_reg <= 4'd0;
    end else begin
      err_run_reg <= err_run_next;
      if (load_word) err_cnt_reg <= err_run_next;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_bpsk_demod_seq.sv
// Self-checking bench for bpsk_demod_seq: N=12 and N=15 instances against a symbol-list reference model.
module tb_bpsk_demod_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [1:0]  sym_in = 2'b00;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic        sym_sop = 1'b0;
  logic [11:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        word_bad;
  logic        drop_pulse;
  logic        busy;
`ifdef SYMERR_CNT_EN
  logic [3:0]  err_cnt;
  logic [3:0]  s15_err_cnt;
`endif

  logic [1:0]  s15_sym_in = 2'b00;
  logic        s15_sym_valid = 1'b0;
  logic        s15_sym_ready;
  logic        s15_sym_sop = 1'b0;
  logic [14:0] s15_word_out;
  logic        s15_word_valid;
  logic        s15_word_ready = 1'b0;
  logic        s15_word_bad;
  logic        s15_drop_pulse;
  logic        s15_busy;

  int checks = 0;
  int failures = 0;
  logic [1:0] q[$];

  always #5 clk = ~clk;

  bpsk_demod_seq #(.N(12)) dut (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .sym_sop(sym_sop), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .word_bad(word_bad),
    .drop_pulse(drop_pulse),
`ifdef SYMERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .busy(busy)
  );

  bpsk_demod_seq #(.N(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .sym_in(s15_sym_in), .sym_valid(s15_sym_valid),
    .sym_ready(s15_sym_ready), .sym_sop(s15_sym_sop), .word_out(s15_word_out),
    .word_valid(s15_word_valid), .word_ready(s15_word_ready), .word_bad(s15_word_bad),
    .drop_pulse(s15_drop_pulse),
`ifdef SYMERR_CNT_EN
    .err_cnt(s15_err_cnt),
`endif
    .busy(s15_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: bit k set unless symbol k is 01; bad if any 00/11
  function automatic logic [31:0] model_word();
    logic [31:0] w = '0;
    foreach (q[k]) if (q[k] != 2'b01) w[k] = 1'b1;
    return w;
  endfunction

  function automatic int model_errs();
    int e = 0;
    foreach (q[k]) if (q[k] == 2'b00 || q[k] == 2'b11) e++;
    return (e > 15) ? 15 : e;
  endfunction

  task automatic send(input logic [1:0] s, input logic sop, input int gap);
    int guard = 0;
    for (int g = 0; g < gap; g++) begin
      sym_valid = 1'b0;
      sym_sop   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    sym_in = s; sym_sop = sop; sym_valid = 1'b1;
    while (!sym_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'(sym_ready), 32'd1);
    @(posedge clk); #1;
    sym_valid = 1'b0; sym_sop = 1'b0;
    if (sop) q.delete();
    q.push_back(s);
    $display("sym %0h sop=%0b count=%0d word_valid=%0b", s, sop, q.size(), word_valid);
  endtask

  task automatic expect_word(input string tag, input int hold);
    logic [11:0] held;
    check({tag, "_valid"}, 32'(word_valid), 32'd1);
    check({tag, "_word"}, 32'(word_out), model_word());
    check({tag, "_bad"}, 32'(word_bad), 32'(model_errs() != 0));
`ifdef SYMERR_CNT_EN
    check({tag, "_err"}, 32'(err_cnt), 32'(model_errs()));
`endif
    held = word_out;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_word"}, 32'(word_out), 32'(held));
      check({tag, "_hold_ready"}, 32'(sym_ready), 32'd0);
      check({tag, "_hold_valid"}, 32'(word_valid), 32'd1);
    end
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    check({tag, "_release_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_release_ready"}, 32'(sym_ready), 32'd1);
    check({tag, "_release_busy"}, 32'(busy), 32'd0);
    $display("word %s out=%03h bad=%0b", tag, held, word_bad);
    q.delete();
  endtask

  initial begin
    logic [1:0] s;
    int guard;
    // reset state
    #1;
    check("rst_ready", 32'(sym_ready), 32'd1);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_word", 32'(word_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_pulse), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // alternating 01,10 back to back
    for (int i = 0; i < 12; i++) begin
      send((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 0);
      if (i < 11) check("alt_early_valid", 32'(word_valid), 32'd0);
    end
    check("alt_const", 32'(word_out), 32'hAAA);
    expect_word("alt", 0);

    // same stream, downstream stalls 5 cycles
    for (int i = 0; i < 12; i++) send((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 0);
    check("stall_busy", 32'(busy), 32'd1);
    expect_word("stall", 5);

    // sop mid-word drops the fragment
    for (int i = 0; i < 5; i++) send(2'b10, 1'b0, 0);
    send(2'b01, 1'b1, 0);
    check("drop_pulse_hi", 32'(drop_pulse), 32'd1);
    send(2'b01, 1'b0, 0);
    check("drop_pulse_lo", 32'(drop_pulse), 32'd0);
    for (int i = 0; i < 10; i++) send(2'b01, 1'b0, 0);
    check("drop_word_const", 32'(word_out), 32'h000);
    expect_word("drop", 1);

    // one non-canonical symbol at position 3
    for (int i = 0; i < 12; i++) send((i == 3) ? 2'b11 : 2'b01, 1'b0, 0);
    check("bad_word_const", 32'(word_out), 32'h008);
    expect_word("bad", 0);

    // reset in the middle of a word
    for (int i = 0; i < 7; i++) send(2'b00, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(sym_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    q.delete();
    @(posedge clk); #1;
    check("midrst_valid", 32'(word_valid), 32'd0);
    for (int i = 0; i < 12; i++) send(2'b10, 1'b0, 0);
    check("midrst_word_const", 32'(word_out), 32'hFFF);
    expect_word("midrst", 0);

    // randomized words with gaps, stray sop without valid, random stalls
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 12; i++) begin
        s = 2'($urandom_range(0, 3));
        send(s, 1'b0, int'($urandom_range(0, 2)));
        if (i < 11) check("rnd_early_valid", 32'(word_valid), 32'd0);
      end
      expect_word("rnd", int'($urandom_range(0, 3)));
    end

    // N=15 instance, all 10 with random valid gaps
    for (int i = 0; i < 15; i++) begin
      for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
        s15_sym_valid = 1'b0;
        @(posedge clk); #1;
      end
      s15_sym_in = 2'b10; s15_sym_valid = 1'b1;
      guard = 0;
      while (!s15_sym_ready && guard < 50) begin
        @(posedge clk); #1; guard++;
      end
      if (guard >= 50) check("n15_ready_timeout", 32'(s15_sym_ready), 32'd1);
      @(posedge clk); #1;
      s15_sym_valid = 1'b0;
      $display("n15 sym %0d word_valid=%0b", i, s15_word_valid);
      check("n15_valid", 32'(s15_word_valid), (i == 14) ? 32'd1 : 32'd0);
    end
    check("n15_word", 32'(s15_word_out), 32'h7FFF);
    check("n15_bad", 32'(s15_word_bad), 32'd0);
    s15_word_ready = 1'b1;
    @(posedge clk); #1;
    s15_word_ready = 1'b0;
    check("n15_release", 32'(s15_word_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bpsk_demod_seq.md
Name: bpsk_demod_seq

Overview:
Symbol-stream sequencer for the BPSK demodulator. Accepts 2-bit BPSK symbols serially over a valid/ready handshake and packs N of them into a 2*N-bit vector. It feeds that vector to an internally instantiated BPSK_demod (parameter n = N) and registers the N-bit demodulated word. The word is handed to the downstream Hamming (N=12) or BCH (N=15) decoder over a second valid/ready handshake.

Parameters:
N, 12, data bits per word = symbols per word; legal 1..15 (12 Hamming, 15 BCH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sym_in  input  2  BPSK symbol; 2'b01 demaps to 0, any other value to 1
sym_valid  input  1  sym_in valid
sym_ready  output  1  block can accept a symbol
sym_sop  input  1  start of word; qualifies the accepted symbol as symbol 0
word_out  output  N  demodulated word; symbol k maps to bit k
word_valid  output  1  word_out valid
word_ready  input  1  downstream accepts word
word_bad  output  1  at least one non-canonical symbol (2'b00 or 2'b11) in word_out; valid with word_valid
drop_pulse  output  1  one-cycle pulse: partial word discarded by sym_sop
busy  output  1  high in COLLECT or HOLD

Behaviour:
- Reset (rst_n low, async): state IDLE, symbol count 0, symbol buffer 0, word_out 0, word_valid 0, word_bad 0, drop_pulse 0, busy 0. sym_ready is decoded combinationally from state, so it reads 1 during reset.
- Symbol accept: sym_valid && sym_ready on the rising edge of clk.
- sym_ready = 1 in IDLE and COLLECT, 0 in HOLD, including the word handshake cycle.
- State IDLE:
  - Accepted symbol (sop ignored) is stored as symbol 0 at buffer[1:0].
  - cnt = 1, bad flag = non-canonical(sym_in).
  - Go to COLLECT, or to HOLD directly if N = 1.
- State COLLECT, accept without sop:
  - Store at buffer[2*cnt+1 : 2*cnt], cnt += 1, OR non-canonical into the bad flag.
  - When the accepted symbol is symbol N-1, go to HOLD.
- State COLLECT, accept with sym_sop = 1:
  - Discard the partial word and pulse drop_pulse for 1 cycle.
  - The symbol becomes symbol 0: cnt = 1, bad flag restarted.
- HOLD entry:
  - word_out is registered from demod(next buffer), so the final symbol is included.
  - word_bad is registered from the final bad flag.
  - word_valid = 1.
  - Latency: word_valid rises in the cycle after the Nth symbol is accepted.
- State HOLD:
  - word_out and word_bad hold stable until word_ready.
  - On word_valid && word_ready: next cycle word_valid = 0, state IDLE, cnt = 0.
  - Maximum throughput: one word per N+1 cycles.
- Buffer bits above the current count are don't-care. Only positions 0..N-1 are ever presented to the demod.
- busy is registered: 1 in COLLECT and HOLD.
- Reset mid-word or mid-HOLD discards everything; no word_valid is produced for the partial word.
- sym_valid gaps in COLLECT simply stall; there is no timeout.
- sym_sop arriving with sym_valid = 0 is ignored.

Optional Feature:
SYMERR_CNT_EN:
- Defined: adds output err_cnt[3:0]. It counts the non-canonical symbols in the held word, saturating at 15, and is registered with word_out. Its reset value is 0 and it restarts on a word start or on sop.
- Undefined: the port is absent and the counter logic is not compiled. word_bad is still present.

Test Plan:
- N=12, 12 symbols alternating 01,10 (01 first), back-to-back -> word_valid 1 cycle after 12th accept, word_out=12'hAAA, word_bad=0.
- Same stream with word_ready held low 5 cycles after word_valid -> word_out stable at 12'hAAA, sym_ready=0 throughout HOLD; word_valid drops the cycle after the handshake, then sym_ready=1.
- 5 symbols of 10, then sym_sop with 01 followed by 11 more 01 -> drop_pulse for exactly 1 cycle, word_out=12'h000, word_bad=0.
- 12 symbols of 01 except symbol 3 = 11 -> word_out=12'h008, word_bad=1; with SYMERR_CNT_EN, err_cnt=1.
- 7 symbols accepted, rst_n pulsed low mid-cycle, then 12 symbols of 10 -> no word from the first fragment; word_out=12'hFFF, word_bad=0.
- N=15, 15 symbols of 10 with random sym_valid gaps -> word_out=15'h7FFF; word_valid only after the 15th accept.
